// File: rtl/tinker_sequencer.sv
// tinker_sequencer: fetch/decode/execute/writeback controller for the combinational tinker_core.
// Latency: 4 clocks per single-cycle instruction, 3+MULTI_LAT for MUL/DIV/FP, plus any fetch wait.
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_ready; nothing else stalls.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   start                   begin execution, sampled only while idle
//   imem_req/addr/ready/data  instruction fetch handshake (addr = pc)
//   core_instr, core_result instruction register out to the core, core result back in
//   rf_we/rf_waddr/rf_wdata register-file write strobe (one cycle per retired instruction)
//   pc, busy, halted        status
// Build option: TINKER_SEQ_PERF_EN adds instr_count (retired-instruction counter).
module tinker_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h2000,
  parameter int          MULTI_LAT = 4,
  parameter logic [4:0]  HALT_OP   = 5'h0F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] core_instr,
  input  logic [63:0] core_result,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [63:0] pc,
  output logic        busy,
  output logic        halted
`ifdef TINKER_SEQ_PERF_EN
  ,
  output logic [31:0] instr_count
`endif
);

  // Non-positive latencies collapse to a single EXEC cycle.
  localparam int LAT_EFF = (MULTI_LAT < 1) ? 1 : MULTI_LAT;
  localparam int LW      = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
  localparam logic [LW-1:0] LAT_LOAD = LW'(LAT_EFF - 1);
  localparam logic [LW-1:0] LAT_ONE  = LW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [63:0]   wdata_q, wdata_d;

  logic [4:0] opcode;
  logic       is_long;

  assign opcode  = ir_q[31:27];
  // MUL/DIV (11100, 11101) and the FP group (10100-10111) need the stretched EXEC window.
  assign is_long = (opcode == 5'b11100) || (opcode == 5'b11101) || (opcode[4:2] == 3'b101);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    lat_d   = lat_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Halt takes priority over the latency class of the opcode.
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          lat_d   = is_long ? LAT_LOAD : '0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_ONE;
        end else begin
          // The core is combinational on ir, so its result is settled on the last EXEC cycle.
          wdata_d = core_result;
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_q + 64'd4;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      lat_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      lat_q   <= lat_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them without a clock.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign core_instr = ir_q;
  assign rf_we      = (state_q == S_WB);
  assign rf_waddr   = ir_q[26:22];
  assign rf_wdata   = wdata_q;
  assign pc         = pc_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                      (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted     = (state_q == S_HALT);

`ifdef TINKER_SEQ_PERF_EN
  logic [31:0] count_q, count_d;

  // Counts WB cycles only; wraps naturally at 2^32.
  assign count_d = (state_q == S_WB) ? (count_q + 32'd1) : count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`endif

endmodule
